// File: rtl/io_switch_cfg_master.sv
// Control-plane initiator for the 4x4 streaming I/O switch: stages routes in a shadow table and
// commits them one output at a time. Define IOSW_CFG_QUIESCE_EN to wait for each output to go quiet first.
module io_switch_cfg_master #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_commit,
  input  logic [1:0] req_dst,
  input  logic [1:0] req_src,
  input  logic [3:0] mon_out_valid,
  output logic [1:0] ctrl_addr,
  output logic       ctrl_wr_en,
  output logic [1:0] ctrl_wr_data,
  output logic       busy,
  output logic       err_timeout,
  output logic [7:0] active_table
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_QUIET, WRITE} state_e;

  state_e     state_q;
  logic [1:0] idx_q;
  logic [1:0] shadow_q [4];
  logic [1:0] active_q [4];
  logic       ready_q;
  logic       wr_en_q;
  logic [1:0] addr_q;
  logic [1:0] data_q;
  logic       differs;
  logic       last_entry;

  assign differs    = shadow_q[idx_q] != active_q[idx_q];
  assign last_entry = idx_q == 2'd3;

`ifdef IOSW_CFG_QUIESCE_EN
  logic [1:0]           quiet_q, quiet_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic                 err_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    quiet_d = mon_out_valid[idx_q] ? 2'd0 : ((quiet_q == 2'd2) ? 2'd2 : quiet_q + 2'd1);
    to_d    = to_q + TIMEOUT_W'(1);
  end

  assign err_timeout = err_q;
`else
  logic [TIMEOUT_W+3:0] unused_cfg;
  assign unused_cfg  = {{TIMEOUT_W{1'b0}}, mon_out_valid};
  assign err_timeout = 1'b0;
`endif

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      // NOTE: both tables are reset because the switch's own route registers also reset to 0.
      shadow_q <= '{default: 2'd0};
      active_q <= '{default: 2'd0};
      ready_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= 2'd0;
      data_q   <= 2'd0;
`ifdef IOSW_CFG_QUIESCE_EN
      quiet_q  <= 2'd0;
      to_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      addr_q  <= 2'd0;
      data_q  <= 2'd0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          // ready_q gates acceptance so nothing is taken in the first cycle after reset
          if (req_valid && ready_q) begin
            if (req_commit) begin
              idx_q   <= 2'd0;
              state_q <= SCAN;
              ready_q <= 1'b0;
`ifdef IOSW_CFG_QUIESCE_EN
              err_q   <= 1'b0;
`endif
            end else begin
              shadow_q[req_dst] <= req_src;
            end
          end
        end
        SCAN: begin
          if (!differs) begin
            if (last_entry) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
`ifdef IOSW_CFG_QUIESCE_EN
            state_q <= WAIT_QUIET;
            quiet_q <= 2'd0;
            to_q    <= '0;
`else
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            addr_q  <= idx_q;
            data_q  <= shadow_q[idx_q];
`endif
          end
        end
`ifdef IOSW_CFG_QUIESCE_EN
        WAIT_QUIET: begin
          quiet_q <= quiet_d;
          to_q    <= to_d;
          if (quiet_d == 2'd2) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            addr_q  <= idx_q;
            data_q  <= shadow_q[idx_q];
          end else if (&to_d) begin
            err_q <= 1'b1;
            if (last_entry) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= SCAN;
              idx_q   <= idx_q + 2'd1;
            end
          end
        end
`endif
        WRITE: begin
          // the switch latches the write on this same edge
          active_q[idx_q] <= shadow_q[idx_q];
          if (last_entry) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= SCAN;
            idx_q   <= idx_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign busy         = state_q != IDLE;
  assign ctrl_wr_en   = wr_en_q;
  assign ctrl_addr    = addr_q;
  assign ctrl_wr_data = data_q;
  assign active_table = {active_q[3], active_q[2], active_q[1], active_q[0]};

endmodule
